seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the team's fixed-pattern FSM detectors.
- Pattern, pattern length and overlap/non-overlap mode are loaded through a config strobe.
- Bits are qualified by a valid strobe.
- Produces a registered one-cycle match pulse and a saturating match counter.
- Sits between a serial deserialiser front end and status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2).
CNT_W, 16, width of the match counter.
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap.
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the earliest-received bit.
cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN.
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping.
x_valid  in  1  qualifies x this cycle.
x  in  1  serial data bit.
z  out  1  match pulse, high for one cycle.
match_count  out  CNT_W  saturating count of matches since reset/config.
armed  out  1  high while a legal configuration is active (RUN state).
cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected.

Behaviour:
Clocking and reset
- All state updates on posedge clk.
- rst has priority over everything. On rst: state=IDLE, hist=0, fill=0, pattern/len/overlap regs=0, z=0, match_count=0, armed=0, cfg_err=0.
- Reset mid-stream discards partial history; there are no pending matches.

State machine, two states
- IDLE: x_valid ignored; z=0; armed=0.
- RUN: armed=1; bits processed.
- cfg_load is accepted in either state:
  - cfg_len in 1..MAX_LEN: latch pattern/len/overlap; hist=0, fill=0, match_count=0; next state RUN.
  - cfg_len==0 or cfg_len>MAX_LEN: cfg_err=1 next cycle; next state IDLE; registers cleared as for reset except match_count, which holds.
- cfg_load and x_valid in the same cycle: config wins; the bit is discarded.

Bit processing (RUN, x_valid=1, no cfg_load)
- hist <= {hist[MAX_LEN-2:0], x}.
- fill <= min(fill+1, MAX_LEN).
- Match condition, evaluated on the post-shift value: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0] (upper bits masked).
- On match:
  - z=1 in the following cycle (latency 1 clk after the completing bit's sampling edge).
  - match_count increments unless already all-ones (saturates, never wraps).
  - overlap=0: fill <= 0, so the next match needs len fresh bits.
  - overlap=1: fill continues, so suffix reuse is allowed.
- x_valid=0: hist, fill and count hold; z=0.
- z is never high for two consecutive cycles unless two consecutive valid bits each complete a match. This is possible with overlap=1; with len=1 every matching valid bit pulses.

Width rules
- fill is LEN_W bits.
- The comparison mask is built from len. There is no out-of-range indexing because len <= MAX_LEN is guaranteed by the accept rule.

Decomposition:
- Package seq_det_pkg:
  - state enum {IDLE, RUN};
  - function len_mask(len) returning a MAX_LEN-bit mask;
  - LEN_W computation.
- Sub-module seq_hist_shift (the shift register plus fill counter, with clear and shift inputs) is a natural split.
- The FSM, match compare and counter stay in the top level.

Test Plan:
- Overlap 11011: cfg pattern=8'b00011011, len=5, overlap=1; stream 1,1,0,1,1,0,1,1 with x_valid=1 continuous -> z pulses after bits 5 and 8; match_count=2.
- Non-overlap 11011: same stream with overlap=0 -> single z after bit 5; bit 8 does not match; match_count=1.
- Non-overlap 1010: len=4; stream 1010101010 -> z after bits 4 and 8 only. Gaps with x_valid=0 inserted between bits -> same result; z only follows valid bits.
- Illegal length: cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses once each; armed=0; x stream produces no z.
- cfg_load coincident with x_valid, and rst asserted after 3 of 5 pattern bits -> the coincident bit is dropped; after reset all outputs are 0; a full pattern is required again before z.
- Saturation: CNT_W=2, len=1, pattern=1, overlap=1; six consecutive 1s -> z high six consecutive cycles; match_count stops at 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Patterns longer than this cannot be compared against the mask.
    localparam int MASK_W = 32;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Ones in bit positions [len-1:0], zeros above.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_hist.sv
// Serial history shift register with a saturating fill counter.
module seq_hist_shift
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic               restart_i,
    output logic [MAX_LEN-1:0] hist_shift_o,
    output logic [LEN_W-1:0]   fill_shift_o
);

    logic [MAX_LEN-1:0] hist_q;
    logic [LEN_W-1:0]   fill_q;

    // Preview of the post-shift values so the match can be judged this cycle.
    assign hist_shift_o = {hist_q[MAX_LEN-2:0], bit_i};
    assign fill_shift_o = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_i) begin
            hist_q <= hist_shift_o;
            fill_q <= restart_i ? '0 : fill_shift_o;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with match pulse and saturating count.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               cfg_ok;
    logic               bit_take;
    logic               match;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_shift;
    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  diff;

    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign bit_take = (state_q == RUN) && x_valid && !cfg_load;

    assign mask  = len_mask(int'(len_q));
    assign diff  = (MASK_W'(hist_shift) ^ MASK_W'(pat_q)) & mask;
    assign match = bit_take && (fill_shift >= len_q) && (diff == '0);

    seq_hist_shift #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (cfg_load),
        .shift_i      (bit_take),
        .bit_i        (x),
        .restart_i    (match && !ovl_q),
        .hist_shift_o (hist_shift),
        .fill_shift_o (fill_shift)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        cnt_d   = cnt_q;
        z_d     = 1'b0;
        err_d   = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                state_d = RUN;
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                ovl_d   = cfg_overlap;
                cnt_d   = '0;
            end else begin
                // Rejected config disarms but keeps the count for status readers.
                state_d = IDLE;
                pat_d   = '0;
                len_d   = '0;
                ovl_d   = 1'b0;
                err_d   = 1'b1;
            end
        end else if (match) begin
            z_d   = 1'b1;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            z_q     <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign armed       = (state_q == RUN);
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench: queue-based reference model of the detector, two DUT widths in lockstep.
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               x_valid;
    logic               x;
    logic               z_a, armed_a, err_a;
    logic               z_b, armed_b, err_b;
    logic [15:0]        cnt_a;
    logic [1:0]         cnt_b;

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
        .cfg_len (cfg_len), .cfg_overlap (cfg_overlap), .x_valid (x_valid), .x (x),
        .z (z_a), .match_count (cnt_a), .armed (armed_a), .cfg_err (err_a)
    );

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_b (
        .clk (clk), .rst (rst), .cfg_load (cfg_load), .cfg_pattern (cfg_pattern),
        .cfg_len (cfg_len), .cfg_overlap (cfg_overlap), .x_valid (x_valid), .x (x),
        .z (z_b), .match_count (cnt_b), .armed (armed_b), .cfg_err (err_b)
    );

    typedef struct {
        logic z;
        int   cnt_a;
        int   cnt_b;
        logic armed;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;

    // Reference model: bits seen since the window last restarted.
    logic       m_armed = 1'b0;
    logic [7:0] m_pat   = '0;
    int         m_len   = 0;
    logic       m_ovl   = 1'b0;
    logic       m_bits[$];
    int         m_cnt_a = 0;
    int         m_cnt_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic step(input logic r, input logic ld, input logic [7:0] pat,
                        input int len, input logic ov, input logic xv, input logic xb);
        exp_t e;
        logic hit;
        @(negedge clk);
        rst = r; cfg_load = ld; cfg_pattern = pat; cfg_len = LEN_W'(len);
        cfg_overlap = ov; x_valid = xv; x = xb;
        e.z = 1'b0; e.err = 1'b0;
        if (r) begin
            m_armed = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_bits.delete();
            m_cnt_a = 0; m_cnt_b = 0;
        end else if (ld) begin
            m_bits.delete();
            if (len >= 1 && len <= MAX_LEN) begin
                m_armed = 1; m_pat = pat; m_len = len; m_ovl = ov;
                m_cnt_a = 0; m_cnt_b = 0;
            end else begin
                m_armed = 0; m_pat = 0; m_len = 0; m_ovl = 0; e.err = 1'b1;
            end
        end else if (m_armed && xv) begin
            m_bits.push_back(xb);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            hit = (m_bits.size() >= m_len);
            for (int k = 0; k < m_len && hit; k++)
                if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 0;
            if (hit) begin
                e.z = 1'b1;
                if (m_cnt_a < 65535) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
                if (!m_ovl) m_bits.delete();
            end
        end
        e.cnt_a = m_cnt_a; e.cnt_b = m_cnt_b; e.armed = m_armed;
        exp_q.push_back(e);
        $display("txn t=%0t rst=%0b ld=%0b len=%0d ov=%0b xv=%0b x=%0b -> z=%0b cnt=%0d/%0d armed=%0b err=%0b",
                 $time, r, ld, len, ov, xv, xb, e.z, e.cnt_a, e.cnt_b, e.armed, e.err);
    endtask

    task automatic cfg(input logic [7:0] pat, input int len, input logic ov);
        step(0, 1, pat, len, ov, 0, 0);
    endtask

    task automatic bits(input logic [15:0] v, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(0, 0, cfg_pattern, int'(cfg_len), cfg_overlap, 1, v[i]);
            if (gaps) step(0, 0, cfg_pattern, int'(cfg_len), cfg_overlap, 0, ~v[i]);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per driven cycle, checked after the edge that produces it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("z_a",     32'(z_a),     32'(e.z));
                check("z_b",     32'(z_b),     32'(e.z));
                check("cnt_a",   32'(cnt_a),   e.cnt_a);
                check("cnt_b",   32'(cnt_b),   e.cnt_b);
                check("armed_a", 32'(armed_a), 32'(e.armed));
                check("armed_b", 32'(armed_b), 32'(e.armed));
                check("err_a",   32'(err_a),   32'(e.err));
                check("err_b",   32'(err_b),   32'(e.err));
            end
        end
    end

    initial begin
        int r, len, wait_cnt;
        rst = 1; cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
        x_valid = 0; x = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        settle();
        check("reset_armed", 32'(armed_a), 0);
        check("reset_cnt",   32'(cnt_a),   0);

        cfg(8'b00011011, 5, 1);
        bits(16'b11011011, 8, 0);
        settle();
        check("ovl_11011_cnt", 32'(cnt_a), 2);

        cfg(8'b00011011, 5, 0);
        bits(16'b11011011, 8, 0);
        settle();
        check("novl_11011_cnt", 32'(cnt_a), 1);

        cfg(8'b00001010, 4, 0);
        bits(16'b1010101010, 10, 0);
        cfg(8'b00001010, 4, 0);
        bits(16'b1010101010, 10, 1);
        settle();
        check("novl_1010_gaps_cnt", 32'(cnt_a), 2);

        cfg(8'b00000001, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        cfg(8'b00000001, MAX_LEN + 1, 0);
        bits(16'hFFFF, 6, 0);
        settle();
        check("illegal_armed", 32'(armed_a), 0);
        check("illegal_cnt_hold", 32'(cnt_a), 2);

        step(0, 1, 8'b00011011, 5, 1, 1, 1);
        bits(16'b1011, 4, 0);
        bits(16'b110, 3, 0);
        step(1, 0, 8'b00011011, 5, 1, 0, 0);
        bits(16'b11, 2, 0);
        settle();
        check("rst_mid_z", 32'(z_a), 0);
        cfg(8'b00011011, 5, 1);
        bits(16'b1111011, 7, 0);

        cfg(8'b00000001, 1, 1);
        bits(16'b111111, 6, 0);
        settle();
        check("sat_cnt_b", 32'(cnt_b), 3);
        check("sat_cnt_a", 32'(cnt_a), 6);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r == 0) begin
                step(1, 0, cfg_pattern, int'(cfg_len), cfg_overlap, 0, 0);
            end else if (r < 4) begin
                r = $urandom_range(0, 9);
                if (r < 6)       len = $urandom_range(1, 4);
                else if (r < 8)  len = $urandom_range(5, MAX_LEN);
                else if (r == 8) len = 0;
                else             len = $urandom_range(MAX_LEN + 1, 15);
                step(0, 1, 8'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                step(0, 0, cfg_pattern, int'(cfg_len), cfg_overlap,
                     ($urandom_range(0, 4) != 0), 1'($urandom));
            end
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #5;
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
